// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage MIPS core.
//   - Datapath widths: DATA_W, ADDR_W, ALUOP_W
//   - ALUOp encodings used by the decoder and the ALU control
//   - ctrl_t: the decoded control bundle carried down the pipeline
//   - REG_ZERO: architectural register $0 (hard-wired zero)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int ALUOP_W = 3;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'd5;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALUOP_W-1:0]  alu_op;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Load-use hazard detector for the ID/EX boundary (purely combinational).
// Ports:
//   valid_i        ID stage holds a real instruction
//   flush_i        ID instruction is being killed by a taken branch/jump
//   rs_addr_i      rs field of the ID instruction
//   rt_addr_i      rt field of the ID instruction
//   uses_rt_i      ID instruction reads rt as a source
//   ex_valid_i     EX stage holds a real instruction
//   ex_mem_read_i  EX instruction is a load
//   ex_rd_addr_i   destination register of the EX instruction
//   haz_o          load-use hazard present
//   stall_o        freeze PC and IF/ID (suppressed when flushing)
// ---------------------------------------------------------------------------
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic              uses_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [ADDR_W-1:0] ex_rd_addr_i,
    output logic              haz_o,
    output logic              stall_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // A load into $0 never produces a value anyone can depend on.
    assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != ADDR_W'(REG_ZERO));
    assign rs_match   = (ex_rd_addr_i == rs_addr_i);
    assign rt_match   = uses_rt_i & (ex_rd_addr_i == rt_addr_i);

    assign haz_o   = valid_i & ex_is_load & (rs_match | rt_match);
    // A flushed instruction is discarded anyway, so holding it would waste a cycle.
    assign stall_o = haz_o & ~flush_i;

endmodule

// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register with load-use hazard detection and saturating
// stall/bubble performance counters.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   valid_i, flush_i          ID instruction valid / kill
//   RSaddr_i..RDaddr_i        ID register addresses, uses_rt_i rt-source flag
//   RSdata_i, RTdata_i, imm_i ID operand data
//   RegWrite_i..ALUOp_i       ID decoded control
//   stall_o                   combinational hold for PC and IF/ID
//   valid_o, *_o              registered EX-stage copies
//   stall_cnt_o, bubble_cnt_o saturating performance counters
// ---------------------------------------------------------------------------
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int ALUOP_W = cpu_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  RSaddr_i,
    input  logic [ADDR_W-1:0]  RTaddr_i,
    input  logic               uses_rt_i,
    input  logic [ADDR_W-1:0]  RDaddr_i,
    input  logic [DATA_W-1:0]  RSdata_i,
    input  logic [DATA_W-1:0]  RTdata_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic               RegWrite_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               MemtoReg_i,
    input  logic               ALUSrc_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  RSaddr_o,
    output logic [ADDR_W-1:0]  RTaddr_o,
    output logic [ADDR_W-1:0]  RDaddr_o,
    output logic [DATA_W-1:0]  RSdata_o,
    output logic [DATA_W-1:0]  RTdata_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic               RegWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               ALUSrc_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam int CTRL_AOP_W = cpu_pkg::ALUOP_W;

    logic               haz;
    logic               bubble;

    logic               valid_d,      valid_q;
    ctrl_t              ctrl_d,       ctrl_q;
    logic [ADDR_W-1:0]  rs_addr_d,    rs_addr_q;
    logic [ADDR_W-1:0]  rt_addr_d,    rt_addr_q;
    logic [ADDR_W-1:0]  rd_addr_d,    rd_addr_q;
    logic [DATA_W-1:0]  rs_data_d,    rs_data_q;
    logic [DATA_W-1:0]  rt_data_d,    rt_data_q;
    logic [DATA_W-1:0]  imm_d,        imm_q;
    logic [CNT_W-1:0]   stall_cnt_d,  stall_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_d, bubble_cnt_q;

    hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .valid_i       (valid_i),
        .flush_i       (flush_i),
        .rs_addr_i     (RSaddr_i),
        .rt_addr_i     (RTaddr_i),
        .uses_rt_i     (uses_rt_i),
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_addr_i  (rd_addr_q),
        .haz_o         (haz),
        .stall_o       (stall_o)
    );

    // Flush and hazard both turn the EX slot into a bubble; the bubble also
    // clears MemRead, which is what limits a load-use stall to one cycle.
    assign bubble = flush_i | haz;

    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        if (!bubble) begin
            valid_d   = valid_i;
            rs_addr_d = RSaddr_i;
            rt_addr_d = RTaddr_i;
            rd_addr_d = RDaddr_i;
            rs_data_d = RSdata_i;
            rt_data_d = RTdata_i;
            imm_d     = imm_i;
            // Invalid slots must never carry live control into EX/MEM/WB.
            if (valid_i) begin
                ctrl_d.reg_write  = RegWrite_i;
                ctrl_d.mem_read   = MemRead_i;
                ctrl_d.mem_write  = MemWrite_i;
                ctrl_d.mem_to_reg = MemtoReg_i;
                ctrl_d.alu_src    = ALUSrc_i;
                ctrl_d.alu_op     = CTRL_AOP_W'(ALUOp_i);
            end
        end
    end

    // Counters stick at all-ones so a long run never reports a small value.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign RSaddr_o     = rs_addr_q;
    assign RTaddr_o     = rt_addr_q;
    assign RDaddr_o     = rd_addr_q;
    assign RSdata_o     = rs_data_q;
    assign RTdata_o     = rt_data_q;
    assign imm_o        = imm_q;
    assign RegWrite_o   = ctrl_q.reg_write;
    assign MemRead_o    = ctrl_q.mem_read;
    assign MemWrite_o   = ctrl_q.mem_write;
    assign MemtoReg_o   = ctrl_q.mem_to_reg;
    assign ALUSrc_o     = ctrl_q.alu_src;
    assign ALUOp_o      = ALUOP_W'(ctrl_q.alu_op);
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe
// Drives instruction vectors into id_ex_pipe, queues the expected EX-stage
// contents at drive time and compares them one edge later. The counters are
// built 4 bits wide so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    // Control packing: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[2:0]}
    localparam logic [7:0] C_ADD_R = 8'b1_0_0_0_0_010;
    localparam logic [7:0] C_LW    = 8'b1_1_0_1_1_000;
    localparam logic [7:0] C_ADDI  = 8'b1_0_0_0_1_000;
    localparam logic [7:0] C_SW    = 8'b0_0_1_0_1_000;
    localparam logic [7:0] C_JUNK  = 8'b1_1_1_0_0_101;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        exp_stall;
        logic        exp_bubble;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        int          stall_cnt;
        int          bubble_cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i, flush_i, uses_rt_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, alu_src_i;
    logic [2:0]  alu_op_i;
    logic        stall_o, valid_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o;
    logic [2:0]  alu_op_o;
    logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;

    int   checks;
    int   failures;
    int   exp_stall_cnt;
    int   exp_bubble_cnt;
    exp_t exp_q[$];
    vec_t vecs[16];

    id_ex_pipe #(
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .RSaddr_i     (rs_addr_i),
        .RTaddr_i     (rt_addr_i),
        .uses_rt_i    (uses_rt_i),
        .RDaddr_i     (rd_addr_i),
        .RSdata_i     (rs_data_i),
        .RTdata_i     (rt_data_i),
        .imm_i        (imm_i),
        .RegWrite_i   (reg_write_i),
        .MemRead_i    (mem_read_i),
        .MemWrite_i   (mem_write_i),
        .MemtoReg_i   (mem_to_reg_i),
        .ALUSrc_i     (alu_src_i),
        .ALUOp_i      (alu_op_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .RSaddr_o     (rs_addr_o),
        .RTaddr_o     (rt_addr_o),
        .RDaddr_o     (rd_addr_o),
        .RSdata_o     (rs_data_o),
        .RTdata_o     (rt_data_o),
        .imm_o        (imm_o),
        .RegWrite_o   (reg_write_o),
        .MemRead_o    (mem_read_o),
        .MemWrite_o   (mem_write_o),
        .MemtoReg_o   (mem_to_reg_o),
        .ALUSrc_o     (alu_src_o),
        .ALUOp_o      (alu_op_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t makeVec(input logic v, input logic f, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic ur, input logic [4:0] rd,
                                     input logic [31:0] rsd, input logic [31:0] rtd,
                                     input logic [31:0] imm, input logic [7:0] ctrl,
                                     input logic es, input logic eb);
        vec_t r;
        r.valid = v;  r.flush = f;  r.rs = rs;  r.rt = rt;  r.uses_rt = ur;  r.rd = rd;
        r.rs_data = rsd;  r.rt_data = rtd;  r.imm = imm;  r.ctrl = ctrl;
        r.exp_stall = es;  r.exp_bubble = eb;
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, " stall_o"},      32'(stall_o), 0);
        checkValue({tag, " valid_o"},      32'(valid_o), 0);
        checkValue({tag, " ctrl"},         32'({reg_write_o, mem_read_o, mem_write_o,
                                                mem_to_reg_o, alu_src_o, alu_op_o}), 0);
        checkValue({tag, " addrs"},        32'({rs_addr_o, rt_addr_o, rd_addr_o}), 0);
        checkValue({tag, " RSdata_o"},     rs_data_o, 0);
        checkValue({tag, " RTdata_o"},     rt_data_o, 0);
        checkValue({tag, " imm_o"},        imm_o, 0);
        checkValue({tag, " stall_cnt_o"},  32'(stall_cnt_o), 0);
        checkValue({tag, " bubble_cnt_o"}, 32'(bubble_cnt_o), 0);
    endtask

    // Pop the oldest expectation and compare it with the EX-stage outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s scoreboard actual=empty required=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        checkValue({tag, " valid_o"},      32'(valid_o), 32'(e.valid));
        checkValue({tag, " RSaddr_o"},     32'(rs_addr_o), 32'(e.rs));
        checkValue({tag, " RTaddr_o"},     32'(rt_addr_o), 32'(e.rt));
        checkValue({tag, " RDaddr_o"},     32'(rd_addr_o), 32'(e.rd));
        checkValue({tag, " RSdata_o"},     rs_data_o, e.rs_data);
        checkValue({tag, " RTdata_o"},     rt_data_o, e.rt_data);
        checkValue({tag, " imm_o"},        imm_o, e.imm);
        checkValue({tag, " ctrl"},         32'({reg_write_o, mem_read_o, mem_write_o,
                                                mem_to_reg_o, alu_src_o, alu_op_o}), 32'(e.ctrl));
        checkValue({tag, " stall_cnt_o"},  32'(stall_cnt_o), e.stall_cnt);
        checkValue({tag, " bubble_cnt_o"}, 32'(bubble_cnt_o), e.bubble_cnt);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        valid_i   = v.valid;    flush_i   = v.flush;    uses_rt_i = v.uses_rt;
        rs_addr_i = v.rs;       rt_addr_i = v.rt;       rd_addr_i = v.rd;
        rs_data_i = v.rs_data;  rt_data_i = v.rt_data;  imm_i     = v.imm;
        {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, alu_src_i, alu_op_i} = v.ctrl;
        #1;
        checkValue({tag, " stall_o"}, 32'(stall_o), 32'(v.exp_stall));
        if (v.exp_stall && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
        if (v.exp_bubble && exp_bubble_cnt < CNT_MAX) exp_bubble_cnt++;
        if (v.exp_bubble) begin
            e = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rs_data: '0, rt_data: '0,
                  imm: '0, ctrl: '0, stall_cnt: 0, bubble_cnt: 0};
        end else begin
            e = '{valid: v.valid, rs: v.rs, rt: v.rt, rd: v.rd, rs_data: v.rs_data,
                  rt_data: v.rt_data, imm: v.imm, ctrl: (v.valid ? v.ctrl : 8'h00),
                  stall_cnt: 0, bubble_cnt: 0};
        end
        e.stall_cnt  = exp_stall_cnt;
        e.bubble_cnt = exp_bubble_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checks = 0;  failures = 0;  exp_stall_cnt = 0;  exp_bubble_cnt = 0;
        rst_n = 1'b0;
        valid_i = 0;  flush_i = 0;  uses_rt_i = 0;
        rs_addr_i = 0;  rt_addr_i = 0;  rd_addr_i = 0;
        rs_data_i = 0;  rt_data_i = 0;  imm_i = 0;
        {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, alu_src_i, alu_op_i} = '0;

        //                  v  f  rs  rt  ur rd  rs_data       rt_data       imm           ctrl     st bb
        vecs[0]  = makeVec(1, 0, 1,  2,  1, 3,  32'h11,       32'h22,       32'hFFFFFFFC, C_ADD_R, 0, 0);
        vecs[1]  = makeVec(1, 0, 1,  2,  0, 2,  32'h100,      32'h0,        32'h4,        C_LW,    0, 0);
        vecs[2]  = makeVec(1, 0, 2,  5,  1, 4,  32'h55,       32'h66,       32'h0,        C_ADD_R, 1, 1);
        vecs[3]  = makeVec(1, 0, 2,  5,  1, 4,  32'h77,       32'h66,       32'h0,        C_ADD_R, 0, 0);
        vecs[4]  = makeVec(1, 0, 1,  0,  0, 0,  32'h200,      32'h0,        32'h8,        C_LW,    0, 0);
        vecs[5]  = makeVec(1, 0, 0,  0,  1, 1,  32'h0,        32'h0,        32'h0,        C_ADD_R, 0, 0);
        vecs[6]  = makeVec(1, 0, 1,  6,  0, 6,  32'h300,      32'h0,        32'hC,        C_LW,    0, 0);
        vecs[7]  = makeVec(1, 0, 8,  6,  0, 7,  32'h88,       32'h99,       32'h10,       C_ADDI,  0, 0);
        vecs[8]  = makeVec(1, 0, 1,  9,  0, 9,  32'h400,      32'h0,        32'h14,       C_LW,    0, 0);
        vecs[9]  = makeVec(1, 1, 9,  3,  1, 10, 32'h12,       32'h34,       32'h0,        C_ADD_R, 0, 1);
        vecs[10] = makeVec(0, 0, 4,  5,  1, 6,  32'hAA,       32'hBB,       32'hCC,       C_JUNK,  0, 0);
        vecs[11] = makeVec(1, 0, 1,  10, 0, 10, 32'h500,      32'h0,        32'h18,       C_LW,    0, 0);
        vecs[12] = makeVec(0, 0, 10, 10, 1, 11, 32'hDD,       32'hEE,       32'h0,        C_ADD_R, 0, 0);
        vecs[13] = makeVec(1, 0, 1,  12, 0, 12, 32'h600,      32'h0,        32'h1C,       C_LW,    0, 0);
        vecs[14] = makeVec(1, 0, 1,  12, 1, 0,  32'h700,      32'hDEAD,     32'h20,       C_SW,    1, 1);
        vecs[15] = makeVec(1, 0, 1,  12, 1, 0,  32'h700,      32'hBEEF,     32'h20,       C_SW,    0, 0);

        #12;
        checkAllZero("reset-idle");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a cycle, EX holding a valid sw.
        checkValue("pre-reset valid_o", 32'(valid_o), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async-reset");
        exp_stall_cnt = 0;  exp_bubble_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(makeVec(1, 0, 1, 2, 1, 3, 32'h1, 32'h2, 32'h0, C_ADD_R, 0, 0), "post-reset add");

        // Seventeen back-to-back flushes must leave the bubble counter stuck at 15.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(makeVec(1, 1, 3, 4, 1, 5, 32'h9, 32'h8, 32'h7, C_ADD_R, 0, 1),
                          $sformatf("flush%0d", i));
        end
        checkValue("saturated bubble_cnt_o", 32'(bubble_cnt_o), CNT_MAX);
        checkValue("saturated stall_cnt_o", 32'(stall_cnt_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the register file and captures RSdata/RTdata, the decoded control bundle, the immediate and the register addresses on the rising edge. It contains the load-use hazard detector: it drives stall_o to freeze PC and IF/ID, and inserts a bubble into EX. Saturating counters for stalls and bubbles support performance debug.

Parameters:
DATA_W, 32, register/immediate data width
ADDR_W, 5, register address width
ALUOP_W, 3, ALUOp field width
CNT_W, 16, width of the stall and bubble performance counters

Ports:
clk_i  in  1  core clock; capture on posedge
rst_i  in  1  asynchronous reset, active-low
valid_i  in  1  ID stage holds a real instruction
flush_i  in  1  branch/jump taken; the ID instruction must be killed
RSaddr_i  in  ADDR_W  rs field of ID instruction
RTaddr_i  in  ADDR_W  rt field of ID instruction
uses_rt_i  in  1  ID instruction reads rt as a source (R-type, beq, sw)
RDaddr_i  in  ADDR_W  destination already muxed (rd or rt)
RSdata_i  in  DATA_W  register file rs read data (stable after negedge)
RTdata_i  in  DATA_W  register file rt read data
imm_i  in  DATA_W  sign-extended immediate
RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i  in  1 each  ID control
ALUOp_i  in  ALUOP_W  ID ALU operation
stall_o  out  1  combinational; hold PC and IF/ID this cycle
valid_o  out  1  EX instruction is real
RSaddr_o, RTaddr_o, RDaddr_o  out  ADDR_W  registered addresses (for forwarding)
RSdata_o, RTdata_o, imm_o  out  DATA_W  registered data
RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o  out  1 each  registered control
ALUOp_o  out  ALUOP_W  registered ALU op
stall_cnt_o, bubble_cnt_o  out  CNT_W  saturating performance counters

Behaviour:
- Reset (rst_i=0, any time, asynchronous): every registered output and both counters go to 0, and valid_o=0. Reset takes effect mid-operation without waiting for a clock edge.
- Hazard: haz = valid_i & valid_o & MemRead_o & (RDaddr_o!=0) & ((RDaddr_o==RSaddr_i) | (uses_rt_i & RDaddr_o==RTaddr_i)).
- stall_o = haz & ~flush_i. It is purely combinational and is 0 during reset.
- Each posedge, the block takes exactly one of three actions, in this priority order:
  1. flush_i=1: insert a bubble.
  2. haz=1: insert a bubble.
  3. Otherwise: capture all inputs, with valid_o<=valid_i.
- Bubble: valid_o and all control outputs go to 0; the address, data and imm outputs also go to 0, for determinism.
- Control gating: if valid_i=0 on a capture, control outputs are registered as 0 regardless of their inputs.
- Latency: one cycle, inputs to outputs.
- Stall length: a load-use stall lasts exactly one cycle, because the bubble clears MemRead_o. The instruction held in ID is recaptured on the next edge with fresh register data.
- Register $0: a destination of 0 never causes a stall.
- No write-back bypass is needed. The register file writes at posedge and reads at negedge, so the value written in WB is visible in RSdata_i within the same cycle.
- stall_cnt_o increments on every posedge where stall_o=1.
- bubble_cnt_o increments on every posedge where a bubble is inserted, from either flush or hazard.
- Both counters saturate at all-ones and never wrap.

Decomposition:
- Shared package cpu_pkg: ADDR_W, DATA_W and ALUOP_W constants; the ALUOp encodings; a ctrl bundle typedef {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp}; REG_ZERO=0.
- One natural sub-module: hazard_detect (combinational haz/stall_o). Counters and registers stay inline.

Test Plan:
- Reset: rst_i=0 mid-run with valid_o=1 -> all outputs 0 immediately, before any clock edge. Release, then capture add $3,$1,$2 -> valid_o=1 one cycle later.
- Pass-through: RSdata_i=0x11, RTdata_i=0x22, imm_i=0xFFFFFFFC, RegWrite_i=1, ALUOp_i=2 -> identical values on outputs after one edge; stall_o=0.
- Load-use: lw $2 captured (MemRead_o=1, RDaddr_o=2), then ID add $4,$2,$5 -> stall_o=1 for one cycle, a bubble in EX (valid_o=0), then the add is captured. stall_cnt_o=1, bubble_cnt_o=1.
- rt and $0 corner cases:
  - lw $0 followed by use of $0 -> stall_o=0.
  - lw $6 followed by addi $7,$8,imm with RTaddr_i=6 and uses_rt_i=0 -> stall_o=0.
- Flush and hazard together: hazard condition true with flush_i=1 -> stall_o=0, a bubble inserted, bubble_cnt_o+1, stall_cnt_o unchanged.
- Saturation: with CNT_W=4, force 17 consecutive bubbles via flush_i -> bubble_cnt_o holds at 15.
